// File: rtl/dmem_sequencer_if.sv
// Bundle of every signal the data-memory sequencer exchanges with the M stage,
// the hazard unit, the host/debug loader and the single-port memory.
//   slave  : the sequencer (takes requests and mem_rdata, drives results/memory)
//   master : pipeline + host + memory side (the opposite directions)
// Vector data is a packed [LANES-1:0][31:0]; lane i occupies bits [32i+31:32i].
interface dmem_sequencer_if #(
    parameter int LANES = 4,
    parameter int AW    = 32
);
    // M-stage request
    logic                   memreq_M;
    logic                   memwrite_M;
    logic                   vector_M;
    logic [AW-1:0]          addr_M;
    logic [31:0]            wdata_M;
    logic [LANES-1:0][31:0] vwdata_M;
    // M-stage results and stall
    logic [31:0]            rdata_M;
    logic [LANES-1:0][31:0] vrdata_M;
    logic                   busy;
    // host / debug loader
    logic                   hreq;
    logic                   hwe;
    logic [AW-1:0]          haddr;
    logic [31:0]            hwdata;
    logic                   hgnt;
    logic                   hvalid;
    logic [31:0]            hrdata;
    // memory port
    logic [AW-1:0]          mem_addr;
    logic                   mem_we;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;

    modport slave (
        input  memreq_M, memwrite_M, vector_M, addr_M, wdata_M, vwdata_M,
        input  hreq, hwe, haddr, hwdata, mem_rdata,
        output rdata_M, vrdata_M, busy, hgnt, hvalid, hrdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output memreq_M, memwrite_M, vector_M, addr_M, wdata_M, vwdata_M,
        output hreq, hwe, haddr, hwdata, mem_rdata,
        input  rdata_M, vrdata_M, busy, hgnt, hvalid, hrdata,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_sequencer.sv
// dmem_sequencer: owns the single-port data memory and splits M-stage scalar
// and vector loads/stores into one-word beats. busy stalls the pipeline while
// an access is in flight. A host/debug loader shares the port; the pipeline
// has strict priority unless HOST_STARVE_EN is defined, in which case a host
// kept waiting STARVE_LIMIT cycles is granted over a pending pipeline request.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; aborts any op in progress
//   bus   - dmem_sequencer_if.slave (M-stage request/result, busy, host
//           port, memory port; mem_rdata is one cycle behind mem_addr)
// Config macro: HOST_STARVE_EN
// Requires LANES >= 2.
module dmem_sequencer #(
    parameter int LANES        = 4,
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_sequencer_if.slave   bus
);
    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BW-1:0] LAST = BW'(LANES - 1);

    typedef enum logic [2:0] {IDLE, SLD, VLD, VST, DONE} state_t;

    state_t                 state;
    logic [BW-1:0]          beat;
    logic [AW-1:0]          addrHold;
    logic [31:0]            wdataHold;
    logic [31:0]            rdataR;
    logic [LANES-1:0][31:0] vrdataR;
    logic                   hvalidR;

    logic                   forceHost;
    logic                   idle, pipeGo, hostGnt, vldIssue, vstIssue, issue;
    logic [BW-1:0]          laneIdx;
    logic [AW-1:0]          baseAddr, pipeAddr;
    logic [AW-1:0]          curAddr;
    logic [31:0]            curWdata;
    logic                   curWe;

`ifdef HOST_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starveCnt;

    assign forceHost = (state == IDLE) && !reset && bus.hreq &&
                       (starveCnt == CW'(STARVE_LIMIT));

    // Saturates at the limit so a host waiting out a long op is granted in
    // the very next IDLE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starveCnt <= '0;
        else if (hostGnt)
            starveCnt <= '0;
        else if (bus.hreq && starveCnt != CW'(STARVE_LIMIT))
            starveCnt <= starveCnt + 1'b1;
    end
`else
    assign forceHost = 1'b0;
`endif

    // Combinational outputs are gated by reset so an abort is seen in the
    // same cycle even though the M-stage inputs are still asserted.
    assign idle     = (state == IDLE) && !reset;
    assign pipeGo   = idle && bus.memreq_M && !forceHost;
    assign hostGnt  = idle && bus.hreq && (!bus.memreq_M || forceHost);
    // VLD beat b captures lane b and issues lane b+1; VST beat b issues lane b.
    assign vldIssue = (state == VLD) && (beat != LAST) && !reset;
    assign vstIssue = (state == VST) && !reset;
    assign issue    = pipeGo || vldIssue || vstIssue || hostGnt;

    assign laneIdx  = vldIssue ? beat + 1'b1 : (vstIssue ? beat : '0);
    assign baseAddr = bus.addr_M & ~AW'(3);
    assign pipeAddr = baseAddr + AW'({laneIdx, 2'b00});   // wraps mod 2^AW

    always_comb begin
        curAddr  = addrHold;
        curWdata = wdataHold;
        curWe    = 1'b0;
        if (hostGnt) begin
            curAddr  = bus.haddr;
            curWdata = bus.hwdata;
            curWe    = bus.hwe;
        end else if (pipeGo || vldIssue || vstIssue) begin
            curAddr  = pipeAddr;
            curWdata = bus.vector_M ? bus.vwdata_M[laneIdx] : bus.wdata_M;
            curWe    = vstIssue || (pipeGo && bus.memwrite_M);
        end
    end

    // Scalar store completes in its single IDLE cycle; the last VST beat
    // releases the pipeline while its write is still on the port.
    assign bus.busy = !reset &&
        ((bus.memreq_M && (state != DONE) &&
          !((state == IDLE) && bus.memwrite_M && !bus.vector_M) &&
          !((state == VST) && (beat == LAST))) || forceHost);

    assign bus.hgnt      = hostGnt;
    assign bus.mem_addr  = curAddr;
    assign bus.mem_we    = curWe;
    assign bus.mem_wdata = curWdata;
    assign bus.rdata_M   = rdataR;
    assign bus.vrdata_M  = vrdataR;
    assign bus.hvalid    = hvalidR;
    assign bus.hrdata    = hvalidR ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            addrHold  <= '0;
            wdataHold <= '0;
            rdataR    <= '0;
            vrdataR   <= '0;
            hvalidR   <= 1'b0;
        end else begin
            hvalidR <= hostGnt && !bus.hwe;
            // Idle port cycles keep presenting the last address/data.
            if (issue) begin
                addrHold  <= curAddr;
                wdataHold <= curWdata;
            end
            case (state)
                IDLE: begin
                    if (pipeGo) begin
                        if (bus.vector_M && bus.memwrite_M) begin
                            state <= VST;
                            beat  <= BW'(1);
                        end else if (bus.vector_M) begin
                            state <= VLD;
                            beat  <= '0;
                        end else if (!bus.memwrite_M) begin
                            state <= SLD;
                        end
                    end
                end
                SLD: begin
                    rdataR <= bus.mem_rdata;
                    state  <= DONE;
                end
                VLD: begin
                    vrdataR[beat] <= bus.mem_rdata;
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                VST: begin
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
